// File: rtl/seq_det_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seq_det_ctrl : programmable serial pattern detector with run control       |
// | Optional idle-run timeout enabled by macro SEQ_DET_TIMEOUT_EN              |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 4
`ifdef SEQ_DET_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               signal,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
`ifdef SEQ_DET_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    localparam logic [LEN_W-1:0] C_LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] C_MAX_LEN  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] C_FILL_MAX = LEN_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [MAX_LEN-1:0]   r_pat;
    logic [LEN_W-1:0]     r_len;
    logic                 r_ovl;
    logic [CNT_W-1:0]     r_tgt;

    logic [MAX_LEN-2:0]   r_hist;
    logic [MAX_LEN-2:0]   w_hist_nxt;
    logic [LEN_W-1:0]     r_fill;
    logic [LEN_W-1:0]     w_fill_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    logic [LEN_W-1:0]     w_cfg_len;
    logic [MAX_LEN-1:0]   w_window;
    logic [MAX_LEN-1:0]   w_mask;
    logic [LEN_W-1:0]     w_len_m1;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_hit;
    logic                 w_fill_ok;

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int               TMO_W       = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] C_TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] C_TMO_ONE   = TMO_W'(1);
    logic [TMO_W-1:0]     r_tmo;
    logic [TMO_W-1:0]     w_tmo_nxt;
`endif

    always_comb begin
        w_cfg_len = cfg_len;
        if (cfg_len == '0) begin
            w_cfg_len = C_LEN_ONE;
        end else if (cfg_len > C_MAX_LEN) begin
            w_cfg_len = C_MAX_LEN;
        end
    end

    // Only the low len bits of the window take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_window  = {r_hist, signal};
    assign w_hit     = ((w_window ^ r_pat) & w_mask) == '0;
    assign w_len_m1  = r_len - C_LEN_ONE;
    assign w_fill_ok = (r_fill >= w_len_m1);
    assign w_cnt_inc = r_cnt + C_CNT_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_cnt_nxt   = r_cnt;
        match       = 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
        w_tmo_nxt   = '0;
        timeout     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_hist_nxt  = '0;
                    w_fill_nxt  = '0;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hist_nxt = w_window[MAX_LEN-2:0];
                    w_fill_nxt = (r_fill == C_FILL_MAX) ? r_fill : r_fill + C_LEN_ONE;
`ifdef SEQ_DET_TIMEOUT_EN
                    w_tmo_nxt  = r_tmo + C_TMO_ONE;
`endif
                    if (w_fill_ok && w_hit) begin
                        match = 1'b1;
                        if (r_cnt != '1) begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                        // Non-overlapping: the next match must be built from fresh bits.
                        if (!r_ovl) begin
                            w_hist_nxt = '0;
                            w_fill_nxt = '0;
                        end
                        if ((r_tgt != '0) && (w_cnt_inc == r_tgt)) begin
                            w_state_nxt = S_DONE;
                        end
`ifdef SEQ_DET_TIMEOUT_EN
                        w_tmo_nxt = '0;
                    end else if (r_tmo == C_TMO_LAST) begin
                        timeout     = 1'b1;
                        w_state_nxt = S_IDLE;
`endif
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hist  <= '0;
            r_fill  <= '0;
            r_cnt   <= '0;
`ifdef SEQ_DET_TIMEOUT_EN
            r_tmo   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef SEQ_DET_TIMEOUT_EN
            r_tmo   <= w_tmo_nxt;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat <= MAX_LEN'(11);
            r_len <= LEN_W'(4);
            r_ovl <= 1'b0;
            r_tgt <= '0;
        end else if ((r_state == S_IDLE) && cfg_valid) begin
            r_pat <= cfg_pattern;
            r_len <= w_cfg_len;
            r_ovl <= cfg_overlap;
            r_tgt <= cfg_target;
        end
    end

    assign cfg_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_seq_det_ctrl : scoreboard bench for seq_det_ctrl                         |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       signal = 1'b0;
    logic       match;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;
`ifdef SEQ_DET_TIMEOUT_EN
    logic       timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_q[$];
    logic [7:0] m_cnt = '0;

    seq_det_ctrl #(
        .MAX_LEN(8),
        .CNT_W  (8),
        .LEN_W  (4)
`ifdef SEQ_DET_TIMEOUT_EN
        ,
        .TIMEOUT(8)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_target (cfg_target),
        .start      (start),
        .abort      (abort),
        .signal     (signal),
        .match      (match),
        .match_cnt  (match_cnt),
        .busy       (busy),
        .done       (done)
`ifdef SEQ_DET_TIMEOUT_EN
        ,
        .timeout    (timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cfg_start(input logic use_cfg, input logic [7:0] pat, input logic [3:0] len,
                             input logic ovl, input logic [7:0] tgt);
        @(negedge clk);
        cfg_valid   = use_cfg;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_target  = tgt;
        start       = 1'b1;
        signal      = 1'b0;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        start     = 1'b0;
        m_cnt     = '0;
    endtask

    // Drive one serial bit; the expected Mealy flag goes into the scoreboard.
    task automatic step_bit(input logic s, input logic exp_m);
        logic e;
        @(negedge clk);
        signal = s;
        exp_q.push_back(exp_m);
        #2;
        e = exp_q.pop_front();
        check("match", 32'(match), 32'(e));
        check("match_cnt", 32'(match_cnt), 32'(m_cnt));
        check("busy", 32'(busy), 32'd1);
        if (e) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic run_bits(input logic [15:0] bits, input logic [15:0] exps, input int n);
        for (int i = n - 1; i >= 0; i--) step_bit(bits[i], exps[i]);
    endtask

    task automatic do_abort(input logic s);
        logic e;
        @(negedge clk);
        signal = s;
        abort  = 1'b1;
        exp_q.push_back(1'b0);
        #2;
        e = exp_q.pop_front();
        check("abort_match", 32'(match), 32'(e));
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_ready", 32'(cfg_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cnt", 32'(match_cnt), 32'(m_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Default 1011 config
        cfg_start(1'b0, 8'h00, 4'd0, 1'b0, 8'd0);
        run_bits(16'b010111, 16'b000010, 6);
        do_abort(1'b0);

        // Non-overlap vs overlap
        cfg_start(1'b1, 8'b1011, 4'd4, 1'b0, 8'd0);
        run_bits(16'b1011011, 16'b0001000, 7);
        do_abort(1'b0);
        cfg_start(1'b1, 8'b1011, 4'd4, 1'b1, 8'd0);
        run_bits(16'b1011011, 16'b0001001, 7);
        do_abort(1'b0);

        // Abort on a would-be match
        cfg_start(1'b1, 8'b1011, 4'd4, 1'b0, 8'd0);
        run_bits(16'b101, 16'b000, 3);
        do_abort(1'b1);

        // Target completion
        cfg_start(1'b1, 8'b110, 4'd3, 1'b0, 8'd2);
        run_bits(16'b110110, 16'b001001, 6);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_ready", 32'(cfg_ready), 32'd0);
        check("done_match", 32'(match), 32'd0);
        check("done_cnt", 32'(match_cnt), 32'd2);
        @(posedge clk);
        #1;
        check("done_clear", 32'(done), 32'd0);
        check("idle_ready", 32'(cfg_ready), 32'd1);
        check("idle_cnt", 32'(match_cnt), 32'd2);

        // Length clamping
        cfg_start(1'b1, 8'b1, 4'd0, 1'b0, 8'd0);
        run_bits(16'b101, 16'b101, 3);
        do_abort(1'b0);
        cfg_start(1'b1, 8'b10110011, 4'd12, 1'b0, 8'd0);
        run_bits(16'b10110011, 16'b00000001, 8);
        do_abort(1'b0);
        cfg_start(1'b1, 8'b01, 4'd2, 1'b0, 8'd0);
        run_bits(16'b01, 16'b01, 2);
        do_abort(1'b0);

        // Async reset mid-run restores the default config
        cfg_start(1'b1, 8'b111, 4'd3, 1'b1, 8'd0);
        run_bits(16'b111, 16'b001, 3);
        #1;
        rst = 1'b1;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ready", 32'(cfg_ready), 32'd1);
        check("mrst_cnt", 32'(match_cnt), 32'd0);
        check("mrst_match", 32'(match), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cfg_start(1'b0, 8'h00, 4'd0, 1'b0, 8'd0);
        run_bits(16'b1011, 16'b0001, 4);
        do_abort(1'b0);

`ifdef SEQ_DET_TIMEOUT_EN
        cfg_start(1'b0, 8'h00, 4'd0, 1'b0, 8'd0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            signal = 1'b0;
            #2;
            check("timeout", 32'(timeout), (i == 8) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
        check("tmo_ready", 32'(cfg_ready), 32'd1);
        check("tmo_cnt", 32'(match_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
